// File: rtl/alu_vector_recorder.sv
// alu_vector_recorder: captures live ALU transactions as 101-bit test-vector records
// {A, B, F, Y, Overflow, Zero} into a linear buffer, then streams them back one record per
// accepted read request so hardware runs can be dumped as .tv files.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   arm, stop         start (clears buffer) / end a capture
//   cap_valid         A/B/F/Y/Overflow/Zero form one transaction this cycle
//   A, B, F, Y        ALU operands, function code and result
//   Overflow, Zero    ALU flags
//   rd_req            request the next record (DONE state only)
//   rd_valid/rd_data  one-cycle beat carrying a record, 1 cycle after rd_req
//   rd_last           qualifies the final record of the readout
//   count, full       records captured, count == DEPTH
//   dropped           sticky: a transaction was refused because the buffer was full
//   busy, done        registered decodes of CAPTURE / DONE
module alu_vector_recorder #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          stop,
  input  logic          cap_valid,
  input  logic [31:0]   A,
  input  logic [31:0]   B,
  input  logic [2:0]    F,
  input  logic [31:0]   Y,
  input  logic          Overflow,
  input  logic          Zero,
  input  logic          rd_req,
  output logic          rd_valid,
  output logic [100:0]  rd_data,
  output logic          rd_last,
  output logic [AW:0]   count,
  output logic          full,
  output logic          dropped,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic          dropped_q, busy_q, done_q;
  logic          rd_valid_q, rd_last_q;
  logic [100:0]  rd_data_q;
  logic [100:0]  mem [DEPTH];

  logic          full_w;
  logic          wr_en;
  logic          rd_en;
  logic [100:0]  wr_rec;

  assign wr_rec = {A, B, F, Y, Overflow, Zero};
  assign full_w = (count_q == DepthCnt);
  assign wr_en  = (state_q == StCapture) && cap_valid && !full_w;
  assign rd_en  = (state_q == StDone) && rd_req && (rd_ptr_q < count_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (arm) state_d = StCapture;
      StCapture: if (stop) state_d = StDone;
      // Leave after the last beat has been presented, or at once when nothing was captured.
      StDone:    if ((rd_valid_q && rd_last_q) || (count_q == '0)) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      dropped_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d == StCapture);
      done_q     <= (state_d == StDone);
      rd_valid_q <= rd_en;
      rd_last_q  <= rd_en && (rd_ptr_q == count_q - CW'(1));

      if ((state_q == StIdle) && arm) begin
        count_q   <= '0;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        dropped_q <= 1'b0;
      end

      if (wr_en) begin
        count_q <= count_q + CW'(1);
        // Linear buffer: the pointer parks on the last slot instead of wrapping.
        if (wr_ptr_q != LastAddr) wr_ptr_q <= wr_ptr_q + AW'(1);
      end

      if ((state_q == StCapture) && cap_valid && full_w) dropped_q <= 1'b1;

      if (rd_en) begin
        rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        rd_ptr_q  <= rd_ptr_q + CW'(1);
      end
    end
  end

  // Plain write port, no reset, so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_rec;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign count    = count_q;
  assign full     = full_w;
  assign dropped  = dropped_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_vector_recorder.sv
// Self-checking bench for alu_vector_recorder: a queue-based model of the capture/readout
// behaviour compared every cycle, plus literal expectations for the directed scenarios.
module tb_alu_vector_recorder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic         clk = 1'b0;
  logic         reset, arm, stop, cap_valid, Overflow, Zero, rd_req;
  logic [31:0]  A, B, Y;
  logic [2:0]   F;
  logic         rd_valid, rd_last, full, dropped, busy, done;
  logic [100:0] rd_data;
  logic [AW:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_vector_recorder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .cap_valid(cap_valid),
    .A(A), .B(B), .F(F), .Y(Y), .Overflow(Overflow), .Zero(Zero), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .count(count),
    .full(full), .dropped(dropped), .busy(busy), .done(done)
  );

  // Model: captured records in a queue, a read index, and two mode flags.
  logic [100:0] recs[$];
  int           rd_idx = 0;
  bit           capturing = 0;
  bit           reading = 0;
  logic         m_rd_valid = 1'b0;
  logic         m_rd_last = 1'b0;
  logic         m_dropped = 1'b0;
  logic [100:0] m_rd_data = '0;
  bit           chk_en = 0;
  logic [100:0] beats[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit last_beat;
    last_beat  = m_rd_valid && m_rd_last;
    m_rd_valid = 1'b0;
    m_rd_last  = 1'b0;
    if (reset) begin
      recs.delete();
      rd_idx    = 0;
      capturing = 0;
      reading   = 0;
      m_dropped = 1'b0;
      m_rd_data = '0;
    end else if (capturing) begin
      if (cap_valid) begin
        if (recs.size() < DEPTH) recs.push_back({A, B, F, Y, Overflow, Zero});
        else m_dropped = 1'b1;
      end
      if (stop) begin
        capturing = 0;
        reading   = 1;
      end
    end else if (reading) begin
      if (last_beat || recs.size() == 0) begin
        reading = 0;
      end else if (rd_req && rd_idx < recs.size()) begin
        m_rd_valid = 1'b1;
        m_rd_data  = recs[rd_idx];
        m_rd_last  = (rd_idx == recs.size() - 1);
        rd_idx++;
      end
    end else if (arm) begin
      capturing = 1;
      recs.delete();
      rd_idx    = 0;
      m_dropped = 1'b0;
    end
  endtask

  // Compare process: advance the model on each edge, sample the DUT 1 time unit later.
  always @(posedge clk) begin
    model_step();
    if (reset) chk_en = 1;
    #1;
    if (chk_en) begin
      check("rd_valid", 128'(rd_valid), 128'(m_rd_valid));
      check("rd_data", 128'(rd_data), 128'(m_rd_data));
      check("rd_last", 128'(rd_last), 128'(m_rd_last));
      check("count", 128'(count), 128'(recs.size()));
      check("full", 128'(full), 128'(recs.size() == DEPTH));
      check("dropped", 128'(dropped), 128'(m_dropped));
      check("busy", 128'(busy), 128'(capturing));
      check("done", 128'(done), 128'(reading));
      if (rd_valid === 1'b1) beats.push_back(rd_data);
    end
  end

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic cap(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                     input logic [31:0] y, input logic o, input logic z);
    cap_valid = 1'b1;
    A = a; B = b; F = f; Y = y; Overflow = o; Zero = z;
    @(negedge clk);
    cap_valid = 1'b0;
  endtask

  task automatic read_hold(input int n);
    rd_req = 1'b1;
    repeat (n) @(negedge clk);
    rd_req = 1'b0;
  endtask

  logic [100:0] exp_rec;

  initial begin
    reset = 1'b1; arm = 1'b0; stop = 1'b0; cap_valid = 1'b0; rd_req = 1'b0;
    A = '0; B = '0; F = '0; Y = '0; Overflow = 1'b0; Zero = 1'b0;
    repeat (2) @(negedge clk);
    check("reset count", 128'(count), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    reset = 1'b0;

    // Three transactions, read back with rd_req held.
    beats.delete();
    pulse_arm();
    cap(32'd5, 32'd3, 3'b010, 32'd8, 1'b0, 1'b0);
    cap(32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000, 1'b1, 1'b0);
    cap(32'd4, 32'd4, 3'b110, 32'd0, 1'b0, 1'b1);
    check("t1 count", 128'(count), 128'(3));
    pulse_stop();
    read_hold(5);
    check("t1 beats", 128'(beats.size()), 128'(3));
    if (beats.size() == 3) begin
      exp_rec = {32'd5, 32'd3, 3'b010, 32'd8, 1'b0, 1'b0};
      check("t1 rec0", 128'(beats[0]), 128'(exp_rec));
      exp_rec = {32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000, 1'b1, 1'b0};
      check("t1 rec1", 128'(beats[1]), 128'(exp_rec));
      exp_rec = {32'd4, 32'd4, 3'b110, 32'd0, 1'b0, 1'b1};
      check("t1 rec2", 128'(beats[2]), 128'(exp_rec));
    end
    check("t1 done fell", 128'(done), 128'(0));

    // Fill past DEPTH.
    beats.delete();
    pulse_arm();
    for (int i = 0; i < DEPTH + 2; i++) begin
      cap(32'(i), 32'(i * 3), 3'b000, 32'(i * 4), 1'b0, 1'b0);
      if (i == DEPTH - 2) check("t2 not full", 128'(full), 128'(0));
      if (i == DEPTH - 1) check("t2 full", 128'(full), 128'(1));
    end
    check("t2 count", 128'(count), 128'(16));
    check("t2 dropped", 128'(dropped), 128'(1));
    repeat (3) @(negedge clk);
    check("t2 busy held", 128'(busy), 128'(1));
    pulse_stop();
    read_hold(DEPTH + 3);
    check("t2 beats", 128'(beats.size()), 128'(16));
    for (int i = 0; i < beats.size(); i++) begin
      check("t2 A", 128'(beats[i][100:69]), 128'(i));
    end

    // Stop and cap_valid together with two records already held.
    beats.delete();
    pulse_arm();
    cap(32'd21, 32'd1, 3'b001, 32'd21, 1'b0, 1'b0);
    cap(32'd22, 32'd2, 3'b001, 32'd22, 1'b0, 1'b0);
    stop = 1'b1;
    cap(32'd23, 32'd3, 3'b001, 32'd23, 1'b0, 1'b0);
    stop = 1'b0;
    check("t3 count", 128'(count), 128'(3));
    check("t3 done", 128'(done), 128'(1));
    read_hold(6);
    check("t3 beats", 128'(beats.size()), 128'(3));

    // Empty capture.
    beats.delete();
    pulse_arm();
    pulse_stop();
    check("t4 done", 128'(done), 128'(1));
    @(negedge clk);
    check("t4 done fell", 128'(done), 128'(0));
    read_hold(3);
    check("t4 no beats", 128'(beats.size()), 128'(0));

    // Gapped reads: one request every third cycle.
    beats.delete();
    pulse_arm();
    for (int i = 0; i < 4; i++) cap(32'(10 + i), 32'd0, 3'b011, 32'(i), 1'b0, 1'b0);
    pulse_stop();
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("t5 beats", 128'(beats.size()), 128'(4));
    for (int i = 0; i < beats.size(); i++) begin
      check("t5 A", 128'(beats[i][100:69]), 128'(10 + i));
    end
    check("t5 idle", 128'(done), 128'(0));

    // Reset after two of four beats, then arm while capturing.
    beats.delete();
    pulse_arm();
    for (int i = 0; i < 4; i++) cap(32'(30 + i), 32'd0, 3'b010, 32'(30 + i), 1'b0, 1'b0);
    pulse_stop();
    read_hold(2);
    reset = 1'b1;
    @(negedge clk);
    check("t6 beats", 128'(beats.size()), 128'(2));
    check("t6 rd_valid", 128'(rd_valid), 128'(0));
    check("t6 rd_data", 128'(rd_data), 128'(0));
    check("t6 rd_last", 128'(rd_last), 128'(0));
    check("t6 count", 128'(count), 128'(0));
    check("t6 full", 128'(full), 128'(0));
    check("t6 dropped", 128'(dropped), 128'(0));
    check("t6 busy", 128'(busy), 128'(0));
    check("t6 done", 128'(done), 128'(0));
    reset = 1'b0;
    pulse_arm();
    cap(32'd40, 32'd0, 3'b010, 32'd40, 1'b0, 1'b0);
    cap(32'd41, 32'd0, 3'b010, 32'd41, 1'b0, 1'b0);
    pulse_arm();
    check("t6 arm ignored", 128'(count), 128'(2));
    check("t6 still busy", 128'(busy), 128'(1));
    pulse_stop();
    read_hold(4);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
